mil_tx_sequencer: RTL and testbench

//   Message-level transmit controller for the MIL-STD-1553 encoder (MIL_TXD).

---
 rtl/mil_pkg.sv | 7 +
 rtl/mil_tx_buf.sv | 21 ++
 rtl/mil_tx_sequencer.sv | 112 +++++++++++
 tb/tb_mil_tx_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/mil_pkg.sv
// mil_pkg: shared MIL-STD-1553 widths, limits and transmit sequencer state encoding
package mil_pkg;
  localparam int MIL_WORD_W  = 16;
  localparam int MIL_MAX_WC  = 32;
  localparam int MIL_WORD_TO = 1200;
  typedef enum logic [1:0] {IDLE, SEND, LAST, WAIT_END} mil_tx_state_e;
endpackage

// File: rtl/mil_tx_buf.sv
// mil_tx_buf: simple dual-port word buffer, one write port and one synchronous read port
//   clk  clock
//   we   write strobe; wa/wd write address/data
//   ra   read address; rd read data, valid the cycle after ra
module mil_tx_buf #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] wd,
  input  logic [AW-1:0] ra,
  output logic [DW-1:0] rd
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    rd <= mem[ra];
  end
endmodule

// File: rtl/mil_tx_sequencer.sv
// mil_tx_sequencer: sends a 1553 command word plus buffered data words to the MIL_TXD encoder
//   Host side : start, cw, wc (0 = 32), no_data, wr_en/wr_addr/wr_data -> busy, done, err
//   Encoder   : tx_dat, tx_en -> MIL_TXD ; tx_T_dat, tx_T_end <- MIL_TXD
//   Optional  : MIL_TXS_WATCHDOG_EN adds a WORD_TO-cycle strobe watchdog driving err
module mil_tx_sequencer
  import mil_pkg::*;
#(
  parameter int BUF_AW  = 5,
  parameter int WORD_TO = MIL_WORD_TO
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [MIL_WORD_W-1:0] cw,
  input  logic [4:0]            wc,
  input  logic                  no_data,
  input  logic                  wr_en,
  input  logic [BUF_AW-1:0]     wr_addr,
  input  logic [MIL_WORD_W-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [MIL_WORD_W-1:0] tx_dat,
  output logic                  tx_en,
  input  logic                  tx_T_dat,
  input  logic                  tx_T_end
);
  if (WORD_TO < 2) begin : g_bad_to
    $error("WORD_TO must be at least 2");
  end
  mil_tx_state_e         state, state_nxt;
  logic [BUF_AW:0]       idx, idx_nxt, n, n_nxt;
  logic [MIL_WORD_W-1:0] tx_dat_nxt, rd_data;
  logic                  tx_en_nxt, done_nxt, wd_exp;
  assign busy = state != IDLE;
  // Address follows the next idx so the word to present is already read out when tx_T_dat arrives.
  mil_tx_buf #(.AW(BUF_AW), .DW(MIL_WORD_W)) u_buf (
    .clk (clk),
    .we  (wr_en && !busy),
    .wa  (wr_addr),
    .wd  (wr_data),
    .ra  (idx_nxt[BUF_AW-1:0]),
    .rd  (rd_data)
  );
`ifdef MIL_TXS_WATCHDOG_EN
  localparam int WDW = $clog2(WORD_TO + 1);
  logic [WDW-1:0] wd;
  logic           strobe;
  assign strobe = tx_T_dat || tx_T_end;
  assign wd_exp = busy && !strobe && wd == WDW'(WORD_TO - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wd <= '0;
    else wd <= (!busy || strobe) ? '0 : wd + 1'b1;
`else
  assign wd_exp = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      n      <= '0;
      tx_en  <= 1'b0;
      tx_dat <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      state  <= state_nxt;
      idx    <= idx_nxt;
      n      <= n_nxt;
      tx_en  <= tx_en_nxt;
      tx_dat <= tx_dat_nxt;
      done   <= done_nxt;
      err    <= wd_exp;
    end
  // idx counts data words already presented; it is one bit wider so n = 32 is representable.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    n_nxt      = n;
    tx_en_nxt  = tx_en;
    tx_dat_nxt = tx_dat;
    done_nxt   = 1'b0;
    case (state)
      IDLE: if (start) begin
        n_nxt      = no_data ? '0 : (wc == 5'd0 ? (BUF_AW+1)'(MIL_MAX_WC) : (BUF_AW+1)'(wc));
        idx_nxt    = '0;
        tx_en_nxt  = 1'b1;
        tx_dat_nxt = cw;
        state_nxt  = n_nxt == '0 ? LAST : SEND;
      end
      SEND: if (tx_T_dat) begin
        tx_dat_nxt = rd_data;
        idx_nxt    = idx + 1'b1;
        state_nxt  = idx_nxt == n ? LAST : SEND;
      end
      LAST: if (tx_T_dat) begin
        tx_en_nxt = 1'b0;
        state_nxt = WAIT_END;
      end
      WAIT_END: if (tx_T_end) begin
        done_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (wd_exp) begin
      state_nxt = IDLE;
      tx_en_nxt = 1'b0;
      done_nxt  = 1'b0;
    end
  end
endmodule

// File: tb/tb_mil_tx_sequencer.sv
// tb_mil_tx_sequencer: randomized scoreboard bench with a behavioural encoder model
module tb_mil_tx_sequencer;
  localparam int WTO = 40;
  logic        clk = 1'b0;
  logic        rst_n, start, no_data, wr_en, busy, done, err, tx_en, tx_T_dat, tx_T_end;
  logic [15:0] cw, wr_data, tx_dat;
  logic [4:0]  wc, wr_addr;
  logic [15:0] mem_m [32];
  logic [15:0] sb [$];
  logic        mute;
  int          compared = 0, mismatched = 0, done_cnt = 0, err_cnt = 0, exp_done = 0;
  always #10 clk = ~clk;
  mil_tx_sequencer #(.BUF_AW(5), .WORD_TO(WTO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cw(cw), .wc(wc), .no_data(no_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
    .err(err), .tx_dat(tx_dat), .tx_en(tx_en), .tx_T_dat(tx_T_dat), .tx_T_end(tx_T_end)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Encoder model: takes each presented word after a random delay, then signals end of transmission.
  initial begin
    tx_T_dat = 1'b0;
    tx_T_end = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_en && !mute) begin
        repeat ($urandom_range(2, 8)) @(posedge clk);
        #1 tx_T_dat = 1'b1;
        @(posedge clk);
        #1 tx_T_dat = 1'b0;
        if (!tx_en) begin
          repeat ($urandom_range(1, 6)) @(posedge clk);
          #1 tx_T_end = 1'b1;
          @(posedge clk);
          #1 tx_T_end = 1'b0;
        end
      end
    end
  end
  // Monitor: every word the encoder takes is checked against the scoreboard.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (tx_T_dat && busy) begin
      chk("tx_en_hold", {31'd0, tx_en}, 32'd1);
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL extra_word: got %h expected none", tx_dat);
      end else chk("word", {16'd0, tx_dat}, {16'd0, sb.pop_front()});
    end
  end
  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    @(posedge clk);
    #1 wr_en = 1'b1; wr_addr = a; wr_data = d; mem_m[a] = d;
    @(posedge clk);
    #1 wr_en = 1'b0;
  endtask
  task automatic launch(input logic [15:0] c, input logic [4:0] w, input logic nd,
                        input logic same_wr, input logic [15:0] d0);
    int n;
    if (same_wr) mem_m[0] = d0;
    n = nd ? 0 : (w == 0 ? 32 : int'(w));
    sb.push_back(c);
    for (int i = 0; i < n; i++) sb.push_back(mem_m[i]);
    @(posedge clk);
    #1 start = 1'b1; cw = c; wc = w; no_data = nd;
    if (same_wr) begin wr_en = 1'b1; wr_addr = 5'd0; wr_data = d0; end
    @(posedge clk);
    #1 start = 1'b0; wr_en = 1'b0; cw = 16'($urandom); wc = 5'($urandom); no_data = 1'($urandom);
    @(negedge clk);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_tx_en", {31'd0, tx_en}, 32'd1);
    chk("start_cw", {16'd0, tx_dat}, {16'd0, c});
  endtask
  task automatic finish_msg();
    int c = 0;
    exp_done++;
    while (!done && c < 3000) begin @(negedge clk); c++; end
    chk("done_seen", {31'd0, done}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    chk("done_once", done_cnt, exp_done);
    chk("sb_empty", sb.size(), 0);
    chk("idle_tx_en", {31'd0, tx_en}, 32'd0);
  endtask
  initial begin
    rst_n = 1'b0; start = 1'b0; cw = '0; wc = '0; no_data = 1'b0; mute = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_en", {31'd0, tx_en}, 32'd0);
    chk("rst_tx_dat", {16'd0, tx_dat}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr(5'd0, 16'h5678);
    launch(16'h1234, 5'd1, 1'b0, 1'b0, 16'h0);
    finish_msg();
    launch(16'hABCD, 5'd0, 1'b1, 1'b0, 16'h0);
    finish_msg();
    for (int i = 0; i < 32; i++) wr(5'(i), 16'(i * 16'h0101));
    launch(16'($urandom), 5'd0, 1'b0, 1'b0, 16'h0);
    finish_msg();
    launch(16'($urandom), 5'd4, 1'b0, 1'b0, 16'h0);
    repeat (6) @(posedge clk);
    #1 start = 1'b1; cw = 16'hFFFF; wr_en = 1'b1; wr_addr = 5'd0; wr_data = 16'hFFFF;
    @(posedge clk);
    #1 start = 1'b0; wr_en = 1'b0;
    finish_msg();
    launch(16'($urandom), 5'd1, 1'b0, 1'b0, 16'h0);
    finish_msg();
    launch(16'($urandom), 5'd2, 1'b0, 1'b1, 16'hC0DE);
    finish_msg();
    launch(16'($urandom), 5'd8, 1'b0, 1'b0, 16'h0);
    repeat (20) @(posedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("async_rst_tx_en", {31'd0, tx_en}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", done_cnt, exp_done);
    launch(16'($urandom), 5'd3, 1'b0, 1'b0, 16'h0);
    finish_msg();
    mute = 1'b1;
    launch(16'($urandom), 5'd2, 1'b0, 1'b0, 16'h0);
    repeat (WTO + 20) @(negedge clk);
`ifdef MIL_TXS_WATCHDOG_EN
    chk("wd_err_once", err_cnt, 1);
    chk("wd_busy", {31'd0, busy}, 32'd0);
    chk("wd_tx_en", {31'd0, tx_en}, 32'd0);
    chk("wd_no_done", done_cnt, exp_done);
    sb.delete();
    mute = 1'b0;
`else
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_tx_en", {31'd0, tx_en}, 32'd1);
    chk("stall_no_err", err_cnt, 0);
    mute = 1'b0;
    finish_msg();
`endif
    for (int m = 0; m < 8; m++) begin
      for (int k = 0; k < 4; k++) wr(5'($urandom), 16'($urandom));
      launch(16'($urandom), 5'($urandom), ($urandom_range(0, 3) == 0), 1'b0, 16'h0);
      finish_msg();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
